// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard blanking between digits,
// leading-zero suppression and a shadow value that only reaches the display at frame boundaries.
module seg7_scan_ctrl #(
    parameter int DIV_BITS = 16,
    parameter int GUARD    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  dp_sel,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack,
    output logic        frame_done
);

    generate
        if (GUARD < 1 || GUARD >= (1 << DIV_BITS)) begin : g_bad_guard
            $error("seg7_scan_ctrl: GUARD must satisfy 1 <= GUARD < 2**DIV_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GUARD,
        ST_DRIVE
    } state_t;

    localparam logic [DIV_BITS-1:0] GUARD_LD = DIV_BITS'(GUARD);

    state_t              r_state;
    logic [DIV_BITS-1:0] r_presc;
    logic [DIV_BITS-1:0] r_guard;
    logic [1:0]          r_idx;
    logic [15:0]         r_shadow;
    logic [15:0]         r_display;
    logic                r_pending;

    logic                w_tick;
    logic [3:0]          w_digit;
    logic                w_allZero;
    logic [6:0]          w_segDecode;
    logic [3:0]          w_anDrive;
    logic [6:0]          w_segDrive;
    logic                w_dpDrive;

    assign w_tick = (r_presc == {DIV_BITS{1'b1}});

    // Digit select plus "this digit and everything above it is zero" for blanking.
    always_comb begin
        w_digit   = r_display[3:0];
        w_allZero = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit   = r_display[3:0];
                w_allZero = 1'b0;
            end
            2'd1: begin
                w_digit   = r_display[7:4];
                w_allZero = (r_display[15:4] == 12'h000);
            end
            2'd2: begin
                w_digit   = r_display[11:8];
                w_allZero = (r_display[15:8] == 8'h00);
            end
            default: begin
                w_digit   = r_display[15:12];
                w_allZero = (r_display[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        w_segDecode = 7'b0001110;
        case (w_digit)
            4'h0: w_segDecode = 7'b1000000;
            4'h1: w_segDecode = 7'b1111001;
            4'h2: w_segDecode = 7'b0100100;
            4'h3: w_segDecode = 7'b0110000;
            4'h4: w_segDecode = 7'b0011001;
            4'h5: w_segDecode = 7'b0010010;
            4'h6: w_segDecode = 7'b0000010;
            4'h7: w_segDecode = 7'b1111000;
            4'h8: w_segDecode = 7'b0000000;
            4'h9: w_segDecode = 7'b0010000;
            4'hA: w_segDecode = 7'b0001000;
            4'hB: w_segDecode = 7'b0000011;
            4'hC: w_segDecode = 7'b1000110;
            4'hD: w_segDecode = 7'b0100001;
            4'hE: w_segDecode = 7'b0000110;
            default: w_segDecode = 7'b0001110;
        endcase
    end

    assign w_anDrive  = ~(4'b0001 << r_idx);
    assign w_segDrive = (lzb && w_allZero) ? 7'h7F : w_segDecode;
    assign w_dpDrive  = ~dp_sel[r_idx];

    // Outputs are loaded with the values belonging to the state being entered, so the
    // registered pins always agree with r_state; idx and display only move on ticks,
    // which always land in GUARD, so the current values are safe to decode here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= en ? ST_GUARD : ST_OFF;
            r_presc    <= '0;
            r_guard    <= GUARD_LD;
            r_idx      <= 2'd0;
            r_shadow   <= 16'h0000;
            r_display  <= 16'h0000;
            r_pending  <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;

            if (load) begin
                r_shadow  <= value_in;
                r_pending <= 1'b1;
            end

            if (!en) begin
                r_state <= ST_OFF;
                r_presc <= '0;
                r_idx   <= 2'd0;
                r_guard <= GUARD_LD;
            end else if (r_state == ST_OFF) begin
                r_state <= ST_GUARD;
                r_presc <= '0;
                r_guard <= GUARD_LD;
            end else begin
                r_presc <= r_presc + 1'b1;
                if (w_tick) begin
                    r_idx   <= r_idx + 2'd1;
                    r_state <= ST_GUARD;
                    r_guard <= GUARD_LD;
                    // A load in the commit cycle keeps pending set for the next frame.
                    if (r_idx == 2'd3) begin
                        frame_done <= 1'b1;
                        if (r_pending) begin
                            r_display <= r_shadow;
                            load_ack  <= 1'b1;
                            if (!load) begin
                                r_pending <= 1'b0;
                            end
                        end
                    end
                end else if (r_state == ST_GUARD) begin
                    if (r_guard == {{(DIV_BITS-1){1'b0}}, 1'b1}) begin
                        r_state <= ST_DRIVE;
                        an      <= w_anDrive;
                        seg     <= w_segDrive;
                        dp      <= w_dpDrive;
                    end else begin
                        r_guard <= r_guard - 1'b1;
                    end
                end else begin
                    an  <= w_anDrive;
                    seg <= w_segDrive;
                    dp  <= w_dpDrive;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV_BITS=4, GUARD=2; n counts clock edges
// since the last reset release and every observation is taken on the falling edge.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_sel;
    logic        lzb;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;
    logic        frame_done;

    int errors;
    int checks;
    int n;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] DARK = 7'h7F;

    seg7_scan_ctrl #(
        .DIV_BITS(4),
        .GUARD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .value_in(value_in),
        .load(load),
        .dp_sel(dp_sel),
        .lzb(lzb),
        .an(an),
        .seg(seg),
        .dp(dp),
        .load_ack(load_ack),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance_to(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; value_in = 16'h0000; load = 1'b0; dp_sel = 4'b0000; lzb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({an, seg, dp} !== {4'b1111, DARK, 1'b1}) begin errors++; $display("[TB] FAIL reset_disp: got %b want %b", {an, seg, dp}, {4'b1111, DARK, 1'b1}); end
        checks++; if ({load_ack, frame_done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b want %b", {load_ack, frame_done}, 2'b00); end
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_scan();
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL scan_n0: got %b want %b", an, 4'b1111); end
        advance_to(1);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL scan_n1: got %b want %b", an, 4'b1111); end
        advance_to(2);
        checks++; if ({an, seg, dp} !== {4'b1110, S0, 1'b1}) begin errors++; $display("[TB] FAIL scan_d0: got %b want %b", {an, seg, dp}, {4'b1110, S0, 1'b1}); end
        advance_to(15);
        checks++; if (an !== 4'b1110) begin errors++; $display("[TB] FAIL scan_n15: got %b want %b", an, 4'b1110); end
        advance_to(16);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL scan_n16: got %b want %b", an, 4'b1111); end
        advance_to(17);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL scan_n17: got %b want %b", an, 4'b1111); end
        advance_to(18);
        checks++; if ({an, seg} !== {4'b1101, S0}) begin errors++; $display("[TB] FAIL scan_d1: got %b want %b", {an, seg}, {4'b1101, S0}); end
    endtask

    task automatic test_load_commit();
        load = 1'b1; value_in = 16'h12A9;
        advance_to(19);
        load = 1'b0;
        advance_to(20);
        checks++; if ({an, seg} !== {4'b1101, S0}) begin errors++; $display("[TB] FAIL hold_d1: got %b want %b", {an, seg}, {4'b1101, S0}); end
        advance_to(50);
        checks++; if ({an, seg} !== {4'b0111, S0}) begin errors++; $display("[TB] FAIL hold_d3: got %b want %b", {an, seg}, {4'b0111, S0}); end
        advance_to(63);
        checks++; if ({load_ack, frame_done} !== 2'b00) begin errors++; $display("[TB] FAIL pre_wrap_pulses: got %b want %b", {load_ack, frame_done}, 2'b00); end
        advance_to(64);
        checks++; if ({load_ack, frame_done, an} !== {2'b11, 4'b1111}) begin errors++; $display("[TB] FAIL commit_pulses: got %b want %b", {load_ack, frame_done, an}, {2'b11, 4'b1111}); end
        advance_to(65);
        checks++; if ({load_ack, frame_done} !== 2'b00) begin errors++; $display("[TB] FAIL commit_one_cycle: got %b want %b", {load_ack, frame_done}, 2'b00); end
        advance_to(66);
        checks++; if ({an, seg} !== {4'b1110, S9}) begin errors++; $display("[TB] FAIL new_d0: got %b want %b", {an, seg}, {4'b1110, S9}); end
        advance_to(82);
        checks++; if ({an, seg} !== {4'b1101, SA}) begin errors++; $display("[TB] FAIL new_d1: got %b want %b", {an, seg}, {4'b1101, SA}); end
        advance_to(96);
        dp_sel = 4'b0100;
        advance_to(98);
        checks++; if ({an, seg, dp} !== {4'b1011, S2, 1'b0}) begin errors++; $display("[TB] FAIL new_d2_dp: got %b want %b", {an, seg, dp}, {4'b1011, S2, 1'b0}); end
        advance_to(114);
        checks++; if ({an, seg, dp} !== {4'b0111, S1, 1'b1}) begin errors++; $display("[TB] FAIL new_d3_dp: got %b want %b", {an, seg, dp}, {4'b0111, S1, 1'b1}); end
        dp_sel = 4'b0000;
        advance_to(128);
        checks++; if ({load_ack, frame_done} !== 2'b01) begin errors++; $display("[TB] FAIL frame_no_pending: got %b want %b", {load_ack, frame_done}, 2'b01); end
    endtask

    task automatic test_lzb();
        lzb = 1'b1;
        advance_to(130);
        load = 1'b1; value_in = 16'h0050;
        advance_to(131);
        load = 1'b0;
        advance_to(192);
        checks++; if ({load_ack, frame_done} !== 2'b11) begin errors++; $display("[TB] FAIL lzb_commit: got %b want %b", {load_ack, frame_done}, 2'b11); end
        advance_to(194);
        checks++; if ({an, seg} !== {4'b1110, S0}) begin errors++; $display("[TB] FAIL lzb_d0: got %b want %b", {an, seg}, {4'b1110, S0}); end
        advance_to(210);
        checks++; if ({an, seg} !== {4'b1101, S5}) begin errors++; $display("[TB] FAIL lzb_d1: got %b want %b", {an, seg}, {4'b1101, S5}); end
        advance_to(226);
        checks++; if ({an, seg} !== {4'b1011, DARK}) begin errors++; $display("[TB] FAIL lzb_d2: got %b want %b", {an, seg}, {4'b1011, DARK}); end
        advance_to(240);
        dp_sel = 4'b1000;
        advance_to(242);
        checks++; if ({an, seg, dp} !== {4'b0111, DARK, 1'b0}) begin errors++; $display("[TB] FAIL lzb_d3_dp: got %b want %b", {an, seg, dp}, {4'b0111, DARK, 1'b0}); end
        lzb = 1'b0; dp_sel = 4'b0000;
        advance_to(243);
        checks++; if ({an, seg, dp} !== {4'b0111, S0, 1'b1}) begin errors++; $display("[TB] FAIL nolzb_d3: got %b want %b", {an, seg, dp}, {4'b0111, S0, 1'b1}); end
    endtask

    task automatic test_back_to_back();
        advance_to(260);
        load = 1'b1; value_in = 16'h3456;
        advance_to(261);
        load = 1'b0;
        advance_to(319);
        load = 1'b1; value_in = 16'h7BCD;
        advance_to(320);
        load = 1'b0;
        checks++; if ({load_ack, frame_done} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_first_ack: got %b want %b", {load_ack, frame_done}, 2'b11); end
        advance_to(321);
        checks++; if (load_ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack_width: got %b want %b", load_ack, 1'b0); end
        advance_to(322);
        checks++; if ({an, seg} !== {4'b1110, S6}) begin errors++; $display("[TB] FAIL b2b_old_d0: got %b want %b", {an, seg}, {4'b1110, S6}); end
        advance_to(338);
        checks++; if ({an, seg} !== {4'b1101, S5}) begin errors++; $display("[TB] FAIL b2b_old_d1: got %b want %b", {an, seg}, {4'b1101, S5}); end
        advance_to(384);
        checks++; if ({load_ack, frame_done} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_second_ack: got %b want %b", {load_ack, frame_done}, 2'b11); end
        advance_to(386);
        checks++; if ({an, seg} !== {4'b1110, SD}) begin errors++; $display("[TB] FAIL b2b_new_d0: got %b want %b", {an, seg}, {4'b1110, SD}); end
        advance_to(402);
        checks++; if ({an, seg} !== {4'b1101, SC}) begin errors++; $display("[TB] FAIL b2b_new_d1: got %b want %b", {an, seg}, {4'b1101, SC}); end
        advance_to(418);
        checks++; if ({an, seg} !== {4'b1011, SB}) begin errors++; $display("[TB] FAIL b2b_new_d2: got %b want %b", {an, seg}, {4'b1011, SB}); end
    endtask

    task automatic test_en_drop();
        advance_to(420);
        en = 1'b0;
        advance_to(421);
        checks++; if ({an, seg, dp} !== {4'b1111, DARK, 1'b1}) begin errors++; $display("[TB] FAIL en_off: got %b want %b", {an, seg, dp}, {4'b1111, DARK, 1'b1}); end
        advance_to(423);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL en_off_hold: got %b want %b", an, 4'b1111); end
        en = 1'b1;
        advance_to(424);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL en_guard1: got %b want %b", an, 4'b1111); end
        advance_to(425);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL en_guard2: got %b want %b", an, 4'b1111); end
        advance_to(426);
        checks++; if ({an, seg} !== {4'b1110, SD}) begin errors++; $display("[TB] FAIL en_restart_d0: got %b want %b", {an, seg}, {4'b1110, SD}); end
        advance_to(442);
        checks++; if ({an, seg} !== {4'b1101, SC}) begin errors++; $display("[TB] FAIL en_restart_d1: got %b want %b", {an, seg}, {4'b1101, SC}); end
    endtask

    task automatic test_reset_pending();
        advance_to(445);
        load = 1'b1; value_in = 16'hFFFF;
        advance_to(446);
        load = 1'b0;
        advance_to(450);
        checks++; if (an !== 4'b1101) begin errors++; $display("[TB] FAIL pre_reset_an: got %b want %b", an, 4'b1101); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({an, seg, dp, load_ack, frame_done} !== {4'b1111, DARK, 1'b1, 2'b00}) begin errors++; $display("[TB] FAIL async_reset: got %b want %b", {an, seg, dp, load_ack, frame_done}, {4'b1111, DARK, 1'b1, 2'b00}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        advance_to(2);
        checks++; if ({an, seg} !== {4'b1110, S0}) begin errors++; $display("[TB] FAIL post_reset_d0: got %b want %b", {an, seg}, {4'b1110, S0}); end
        advance_to(64);
        checks++; if ({load_ack, frame_done} !== 2'b01) begin errors++; $display("[TB] FAIL pending_discarded: got %b want %b", {load_ack, frame_done}, 2'b01); end
        advance_to(66);
        checks++; if ({an, seg} !== {4'b1110, S0}) begin errors++; $display("[TB] FAIL display_cleared: got %b want %b", {an, seg}, {4'b1110, S0}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n = 0;
        test_reset();
        test_scan();
        test_load_commit();
        test_lzb();
        test_back_to_back();
        test_en_drop();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIV_BITS, default 16: prescaler width; one scan tick every 2^DIV_BITS clk cycles.
REQ-002 Parameter GUARD, default 64: blanking cycles between digits (ghost suppression); the design SHALL require 1 <= GUARD < 2^DIV_BITS.
REQ-003 clk  in  1  sole clock; all state on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  scan enable; low forces display dark.
REQ-006 value_in  in  16  four 4-bit digits; [3:0] = digit 0 (least significant).
REQ-007 load  in  1  one-cycle strobe capturing value_in into the shadow register.
REQ-008 dp_sel  in  4  per-digit decimal point, active-high, sampled live.
REQ-009 lzb  in  1  leading-zero blanking enable, sampled live.
REQ-010 an  out  4  anode enables, active-low; an[i] = digit i.
REQ-011 seg  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 load_ack  out  1  one-cycle pulse: shadow committed to display.
REQ-014 frame_done  out  1  one-cycle pulse per completed 4-digit frame.

Function
REQ-015 Prescaler: DIV_BITS-bit up-counter; tick asserted in the cycle it equals 2^DIV_BITS-1; wraps to 0.
REQ-016 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick.
REQ-017 FSM states: OFF, GUARD, DRIVE.
REQ-018 OFF: entered whenever en=0 (from any state, next edge); prescaler and idx held at 0; an=4'b1111, seg=7'h7F, dp=1.
REQ-019 OFF->GUARD on the first edge with en=1; the guard counter SHALL load GUARD.
REQ-020 GUARD: an=4'b1111, seg=7'h7F, dp=1; the guard counter decrements each cycle; GUARD->DRIVE when it reaches 1.
REQ-021 DRIVE: an=~(4'b0001<<idx); seg/dp reflect digit idx; DRIVE->GUARD on tick, with the guard counter reloaded in the same edge as idx advance.
REQ-022 A tick arriving in GUARD SHALL advance idx and reload the guard counter (no DRIVE phase that slot).
REQ-023 Decode: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000, A=7'b0001000, b=7'b0000011, C=7'b1000110, d=7'b0100001, E=7'b0000110, F=7'b0001110.
REQ-024 Leading-zero blanking: with lzb=1, digit i (i=3,2,1) SHALL show seg=7'h7F when it and all higher digits of the display register are 0; digit 0 is never blanked; dp is unaffected by blanking.
REQ-025 dp = ~dp_sel[idx] in DRIVE.
REQ-026 Shadow path: load=1 writes value_in to the shadow and sets pending; a later load before commit overwrites the shadow.
REQ-027 Commit: on the tick where idx wraps 3->0 with pending=1, the display register SHALL take the shadow, pending clears, and load_ack pulses for exactly one cycle at the following edge.
REQ-028 A load coinciding with the commit tick: the old shadow commits, the new value enters the shadow, and pending remains 1.
REQ-029 frame_done SHALL pulse for one cycle at the edge after every 3->0 wrap, independent of pending.
REQ-030 Display register updates only via commit; the displayed value never changes mid-frame.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While reset=1: prescaler=0, idx=0, guard counter=GUARD, state=GUARD if en=1 else OFF, shadow=0, display=0, pending=0.
REQ-033 Output reset values: an=4'b1111, seg=7'h7F, dp=1, load_ack=0, frame_done=0.
REQ-034 Reset asserted mid-frame SHALL abort the scan and discard any pending load, with no load_ack.

Verification (DIV_BITS=4, GUARD=2)
REQ-035 Reset release, en=1, value 0 -> an blank 2 cycles, then 4'b1110 with seg=7'b1000000; idx advances every 16 cycles; blanked an=1111 for 2 cycles after each tick.
REQ-036 load value_in=16'h12A9 mid-frame -> the display stays 0 until the 3->0 wrap; load_ack and frame_done pulse together; next frame digits show 9, A, 2, 1.
REQ-037 lzb=1, value 16'h0050 -> digits 3 and 2 seg=7'h7F, digit 1 shows 5, digit 0 shows 0; with lzb=0 all four are lit.
REQ-038 load on the exact commit tick with a pending shadow -> old shadow displayed, pending=1, the second load_ack one frame later.
REQ-039 en dropped during DRIVE idx=2 -> next cycle an=1111, idx=0; en restored -> GUARD 2 cycles, then digit 0 driven.
REQ-040 reset pulse with pending=1 -> no load_ack, display=0, all outputs at reset values asynchronously.
